shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, fully pipelined barrel shifter for the MIPS datapath, the successor to the single-cycle 32-bit combinational shift-left. It supports four operations: logical left, logical right, arithmetic right and rotate right. It has one log2 stage per pipeline register and valid/ready handshakes on both sides, so it can sit between the register-read and write-back stages of a pipelined core. A sideband tag travels with each operation so the consumer can match results to requests.

## Interface
Parameters:
- WIDTH, 32, data width; must be a power of 2 and at least 2.
- TAG_W, 5, sideband tag width (e.g. destination register number).
- LOG2W, derived localparam, equals $clog2(WIDTH); it is the shift-amount width and the pipeline depth.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted on any edge where in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_shamt  in  LOG2W  shift distance, unsigned, 0..WIDTH-1.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_tag  in  TAG_W  sideband, returned unmodified.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result on any edge where out_valid && out_ready.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Stage k (k = 0..LOG2W-1) conditionally shifts by 2^k when bit k of the carried shamt is 1; otherwise it passes the data through. Each stage output is registered.
- Stage register k holds: valid_k, data_k, the remaining shamt bits [LOG2W-1:k+1], op_k and tag_k.
- Fill rules per stage:
  - SLL: zeros enter at the LSB side.
  - SRL: zeros enter at the MSB side.
  - SRA: the current MSB of the stage input is replicated, which preserves the original sign.
  - ROTR: bits shifted out at the LSB re-enter at the MSB.
- shamt = 0 returns in_data unchanged for every op.
- There is no shamt bit WIDTH; larger distances are the caller's responsibility (MIPS uses 5 bits at WIDTH = 32).
- Global stall: advance = !out_valid || out_ready.
  - When advance = 1, every stage register loads from its predecessor, and stage 0 loads from the input side.
  - When advance = 0, every stage register holds its value.
  - in_ready = advance, purely combinational from out_valid and out_ready. No combinational path exists from in_valid to in_ready.
- Bubbles: when advance = 1 and in_valid = 0, valid_0 loads 0. Bubbles do not collapse: pipeline occupancy is fixed by position, with no skid buffer.
- Order is strictly preserved, and no request is dropped or duplicated.
- The outputs out_valid, out_data and out_tag are driven directly from the last stage register.

## Timing
- Reset: every valid_k is cleared and every data, tag, op and shamt register is cleared to 0, so out_valid = 0, out_data = 0 and out_tag = 0 in the cycle after the reset edge.
  - in_ready = 1 during and after reset.
- rst asserted mid-operation discards all in-flight operations with no output, and overrides a simultaneous accept on the same edge.
- Latency: a request accepted at edge e appears with out_valid = 1 after edge e+LOG2W-1, i.e. LOG2W cycles (5 at WIDTH = 32) when there is no stall.
- Throughput: one operation per cycle while out_ready = 1.
- Stall while full: out_valid = 1 and out_ready = 0 give in_ready = 0, and all registers hold. Output data and tag stay stable for as long as out_valid is high and out_ready is low.
- Simultaneous accept and retire on the same edge is legal and is the steady state.
- out_ready = 0 while out_valid = 0 does not stall the pipeline.

## Structure
- The shared header shift_defs.vh holds the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROTR) as localparams, shared with the ALU control decoder.
- Sub-module shift_stage is a combinational row of 2:1 muxes, parametrised by WIDTH and DIST, with inputs data, en and op, and output data. shift_pipe instantiates it LOG2W times in a generate loop and adds the stage registers and handshake logic.
- Target size is 150-250 lines of RTL in total.

## Test plan
- SLL, WIDTH = 32: in_data 0x0000_0001, shamt 31, tag 3 -> out_data 0x8000_0000, out_tag 3, out_valid exactly 5 cycles after accept.
- SRL vs SRA: 0x8000_0000 with shamt 4 -> SRL gives 0x0800_0000 and SRA gives 0xF800_0000. SRA of 0x7FFF_FFFF with shamt 31 -> 0x0000_0000.
- ROTR: 0x1234_5678 with shamt 8 -> 0x7812_3456. Any op with shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Backpressure: 8 back-to-back requests with tags 0..7, and out_ready held low for 3 cycles once the first result appears. Required response:
  - in_ready = 0 in exactly those 3 cycles;
  - output data and tag are held stable while stalled;
  - results arrive in tag order 0..7 with none lost or duplicated.
- Reset mid-flight: 3 requests in flight, rst pulsed for 1 cycle -> out_valid = 0, out_data = 0 and out_tag = 0 afterwards, and none of the 3 results ever appears. A new request issued after reset completes normally with a 5-cycle latency.
- WIDTH = 8 instance: SLL 0xFF with shamt 7 -> 0x80, and ROTR 0x81 with shamt 1 -> 0xC0, each with a latency of 3 cycles.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// shift_pipe_pkg
// Purpose : shared definitions for the pipelined barrel shifter. The shift
//           operation encodings are also used by the ALU control decoder.
// Contents: OP_W (operation field width) and the four operation codes.
// ---------------------------------------------------------------------------
package shift_pipe_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_SLL  = 2'b00;  // logical left
  localparam logic [OP_W-1:0] OP_SRL  = 2'b01;  // logical right
  localparam logic [OP_W-1:0] OP_SRA  = 2'b10;  // arithmetic right
  localparam logic [OP_W-1:0] OP_ROTR = 2'b11;  // rotate right

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// Purpose : one combinational row of 2:1 muxes of the barrel shifter. When
//           i_en is set the word is shifted by the fixed distance DIST in the
//           direction and with the fill selected by i_op; otherwise it passes
//           through unchanged.
// Ports   : i_data [WIDTH]  stage input word
//           i_en            shift enable (one bit of the shift amount)
//           i_op   [OP_W]   operation code (see shift_pipe_pkg)
//           o_data [WIDTH]  stage output word
// ---------------------------------------------------------------------------
module shift_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        OP_SLL:  o_data = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_SRL:  o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
        // The stage input MSB is still the original sign bit, because every
        // earlier SRA stage replicated it.
        OP_SRA:  o_data = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
        OP_ROTR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        default: o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
// Purpose : fully pipelined barrel shifter (SLL/SRL/SRA/ROTR) with one
//           power-of-two shift stage per pipeline register and valid/ready
//           handshakes on both sides. A tag rides along with each operation.
// Ports   : clk, rst (synchronous, active high)
//           in_valid/in_ready   request handshake
//           in_data  [WIDTH]    operand
//           in_shamt [LOG2W]    shift distance 0..WIDTH-1
//           in_op    [2]        00 SLL, 01 SRL, 10 SRA, 11 ROTR
//           in_tag   [TAG_W]    sideband returned with the result
//           out_valid/out_ready result handshake
//           out_data [WIDTH]    shifted result
//           out_tag  [TAG_W]    tag of the result
// Latency : LOG2W cycles; throughput one operation per cycle.
// ---------------------------------------------------------------------------
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Whole pipeline moves together; it only stops when a finished result is
  // waiting at the output and the consumer refuses it.
  logic w_advance;

  for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
    logic             w_valid_in;
    logic [WIDTH-1:0] w_data_in;
    logic [OP_W-1:0]  w_op_in;
    logic [TAG_W-1:0] w_tag_in;
    logic             w_en;
    logic [WIDTH-1:0] w_data_sh;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;

    if (gi == 0) begin : g_src
      assign w_valid_in = in_valid;
      assign w_data_in  = in_data;
      assign w_op_in    = in_op;
      assign w_tag_in   = in_tag;
      assign w_en       = in_shamt[0];
    end else begin : g_src
      assign w_valid_in = g_stage[gi-1].r_valid;
      assign w_data_in  = g_stage[gi-1].r_data;
      assign w_op_in    = g_stage[gi-1].g_ctl.r_op;
      assign w_tag_in   = g_stage[gi-1].r_tag;
      assign w_en       = g_stage[gi-1].g_ctl.r_shamt[gi];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** gi)
    ) u_stage (
      .i_data (w_data_in),
      .i_en   (w_en),
      .i_op   (w_op_in),
      .o_data (w_data_sh)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_advance) begin
        r_valid <= w_valid_in;
        r_data  <= w_data_sh;
        r_tag   <= w_tag_in;
      end
    end

    // Only stages with a successor carry the op and the not-yet-consumed
    // shift bits [LOG2W-1:gi+1]; the final stage needs neither.
    if (gi < LOG2W - 1) begin : g_ctl
      logic [LOG2W-1:gi+1] w_shamt_in;
      logic [LOG2W-1:gi+1] r_shamt;
      logic [OP_W-1:0]     r_op;

      if (gi == 0) begin : g_sh_src
        assign w_shamt_in = in_shamt[LOG2W-1:1];
      end else begin : g_sh_src
        assign w_shamt_in = g_stage[gi-1].g_ctl.r_shamt[LOG2W-1:gi+1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_shamt <= '0;
          r_op    <= '0;
        end else if (w_advance) begin
          r_shamt <= w_shamt_in;
          r_op    <= w_op_in;
        end
      end
    end
  end

  assign w_advance = !g_stage[LOG2W-1].r_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = g_stage[LOG2W-1].r_valid;
  assign out_data  = g_stage[LOG2W-1].r_data;
  assign out_tag   = g_stage[LOG2W-1].r_tag;

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
// Purpose : self-checking bench for shift_pipe. A 32-bit instance is driven
//           with directed and random traffic and compared against a queue
//           scoreboard fed by an arithmetic shift model; an 8-bit instance
//           covers the narrow configuration.
// ---------------------------------------------------------------------------
module tb_shift_pipe;

  logic clk;
  logic rst;

  // 32-bit instance
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  // 8-bit instance
  logic       v8;
  logic       rdy8;
  logic [7:0] d8;
  logic [2:0] sh8;
  logic [1:0] op8;
  logic [4:0] tag8;
  logic       ov8;
  logic       ordy8;
  logic [7:0] od8;
  logic [4:0] ot8;

  shift_pipe #(.WIDTH(32), .TAG_W(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  shift_pipe #(.WIDTH(8), .TAG_W(5)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .in_ready  (rdy8),
    .in_data   (d8),
    .in_shamt  (sh8),
    .in_op     (op8),
    .in_tag    (tag8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_data  (od8),
    .out_tag   (ot8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain shift arithmetic, rotate built from two shifts.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return sd >>> sh;
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;

  exp_t        sb[$];
  logic        acc;
  logic        ret;
  logic        rdy_s;
  logic [4:0]  tag_s;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_tag;

  // One clock cycle: sample settled handshakes, update scoreboard, take the
  // edge, and return 1 time unit after it with outputs settled.
  task automatic step();
    exp_t e;
    #1;
    acc   = in_valid && in_ready && !rst;
    ret   = out_valid && out_ready && !rst;
    rdy_s = in_ready;
    tag_s = out_tag;
    if (hold_pending) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, held_data);
      check("stall_tag", out_tag, held_tag);
    end
    hold_pending = out_valid && !out_ready && !rst;
    held_data    = out_data;
    held_tag     = out_tag;
    if (ret) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_data", out_data, e.d);
        check("sb_tag", out_tag, e.t);
        $display("txn tag=%0d data=%08h", out_tag, out_data);
      end
    end
    if (acc) begin
      e.d = ref_shift(in_op, in_data, int'(in_shamt));
      e.t = in_tag;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) sb.delete();
    #1;
  endtask

  task automatic run_single(input string name, input logic [1:0] op, input logic [31:0] d,
                            input int sh, input logic [4:0] tag, input logic [31:0] exp);
    int n;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = sh[4:0];
    in_tag    = tag;
    out_ready = 1'b1;
    step();
    check({name, "_acc"}, acc, 1);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_lat"}, n, 5);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, out_tag, tag);
    step();
  endtask

  task automatic run8(input string name, input logic [1:0] op, input logic [7:0] d,
                      input int sh, input logic [7:0] exp);
    int n;
    v8   = 1'b1;
    op8  = op;
    d8   = d;
    sh8  = sh[2:0];
    tag8 = 5'd17;
    #1;
    check({name, "_rdy"}, rdy8, 1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_lat"}, n, 3);
    check({name, "_data"}, od8, exp);
    check({name, "_tag"}, ot8, 17);
    $display("txn w8 %s data=%02h", name, od8);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_data[8];

  initial begin
    int next_tag;
    int stall_left;
    int got;
    int zero_rdy;
    logic stalled;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    v8 = 1'b0; d8 = '0; sh8 = '0; op8 = '0; tag8 = '0; ordy8 = 1'b1;
    step();
    step();
    check("rst_rdy", rdy_s, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_valid8", ov8, 0);
    rst = 1'b0;
    step();

    // Directed operations
    run_single("sll31", 2'b00, 32'h0000_0001, 31, 5'd3, 32'h8000_0000);
    run_single("srl4", 2'b01, 32'h8000_0000, 4, 5'd4, 32'h0800_0000);
    run_single("sra4", 2'b10, 32'h8000_0000, 4, 5'd5, 32'hF800_0000);
    run_single("sra31", 2'b10, 32'h7FFF_FFFF, 31, 5'd6, 32'h0000_0000);
    run_single("rotr8", 2'b11, 32'h1234_5678, 8, 5'd7, 32'h7812_3456);
    for (int op = 0; op < 4; op++)
      run_single($sformatf("sh0_op%0d", op), 2'(op), 32'hDEAD_BEEF, 0, 5'(10 + op), 32'hDEAD_BEEF);

    // Backpressure: 8 back-to-back requests, 3-cycle stall on first result
    for (int i = 0; i < 8; i++) bp_data[i] = $urandom;
    next_tag = 0; stall_left = -1; got = 0; zero_rdy = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid = (next_tag < 8);
      in_tag   = 5'(next_tag);
      in_data  = bp_data[next_tag % 8];
      in_shamt = 5'(next_tag * 3);
      in_op    = 2'(next_tag);
      if (stall_left < 0 && out_valid) stall_left = 3;
      stalled   = (stall_left > 0);
      out_ready = !stalled;
      step();
      check("bp_in_ready", rdy_s, !stalled);
      if (!rdy_s) zero_rdy++;
      if (acc) next_tag++;
      if (ret) begin
        check("bp_order", tag_s, got);
        got++;
      end
      if (stall_left > 0) stall_left--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 8);
    check("bp_stall_cycles", zero_rdy, 3);
    step();

    // Reset mid-flight: three in flight plus an offer on the reset edge
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = 5'(20 + i); in_data = $urandom; in_shamt = 5'd1; in_op = 2'b00;
      step();
    end
    rst = 1'b1; in_tag = 5'd23;
    step();
    check("midrst_rdy", rdy_s, 1);
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_tag", out_tag, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("midrst_ghost", out_valid, 0);
    end
    run_single("post_rst", 2'b00, 32'h0000_0001, 31, 5'd9, 32'h8000_0000);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
        in_tag   = 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("drain_empty", sb.size(), 0);

    // Narrow instance
    run8("w8_sll7", 2'b00, 8'hFF, 7, 8'h80);
    run8("w8_rotr1", 2'b11, 8'h81, 1, 8'hC0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
